eu_exec_pipe: RTL and testbench

// Parametrised execution-unit back end: buffers decoded-format instruction words (instr16 + imm16)
// in an instruction queue, executes reg-reg and imm-reg ALU ops against an internal register file,

---
 rtl/eu_exec_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_eu_exec_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_exec_pipe.sv
// Execution-unit back end: instruction queue feeding a single EX stage
// with register file, 8086-layout flags and a ready/valid result port.
module eu_exec_pipe #(
  parameter int DATA_W   = 16,
  parameter int IQ_DEPTH = 4,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic [15:0]       status,
  output logic              err,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(IQ_DEPTH);
  localparam logic [3:0] NR = 4'(NUM_REGS);

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000010;
  localparam logic [5:0] OP_ADC = 6'b000100;
  localparam logic [5:0] OP_SBB = 6'b000110;
  localparam logic [5:0] OP_AND = 6'b001000;
  localparam logic [5:0] OP_SUB = 6'b001010;
  localparam logic [5:0] OP_XOR = 6'b001100;
  localparam logic [5:0] OP_CMP = 6'b001110;
  localparam logic [5:0] OP_MOV = 6'b100010;

  logic [31:0]       iq_q [IQ_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;
  logic [DATA_W-1:0] rf_q [8];
  logic [15:0]       flags_q, flags_d;
  logic [DATA_W-1:0] result_q, res_d;
  logic              rv_q, err_q;

  logic push, fire, full, empty;

  assign full     = (cnt_q == FULL_C);
  assign empty    = (cnt_q == '0);
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign fire     = !empty && (!rv_q || res_ready) && !flush;

  assign res_valid = rv_q;
  assign result    = result_q;
  assign status    = flags_q;
  assign err       = err_q;
  assign dbg_data  = ({1'b0, dbg_sel} < NR) ? rf_q[dbg_sel] : '0;

  // queue storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) iq_q[wp_q] <= in_word;
  end

  // queue pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (fire) rp_q <= rp_q + 1'b1;
      if (push && !fire)      cnt_q <= cnt_q + 1'b1;
      else if (!push && fire) cnt_q <= cnt_q - 1'b1;
    end
  end

  logic [15:0] ins_w, imm;
  logic [5:0]  op;
  logic        d, w, reg_mode, is_imm;
  logic [1:0]  md;
  logic [2:0]  rg, rm, dst_idx, src_idx;

  assign {ins_w, imm} = iq_q[rp_q];
  assign op       = ins_w[15:10];
  assign d        = ins_w[9];
  assign w        = ins_w[8];
  assign md       = ins_w[7:6];
  assign rg       = ins_w[5:3];
  assign rm       = ins_w[2:0];
  assign reg_mode = (md == 2'b11);
  assign is_imm   = (md == 2'b00);
  assign dst_idx  = (reg_mode && d) ? rg : rm;
  assign src_idx  = d ? rm : rg;

  logic [DATA_W-1:0] a, b, immx, lw, rwid, newv;
  logic [DATA_W:0]   sw, dw, rw;
  logic [8:0]        s8, d8, r8;
  logic [7:0]        rbyt;
  logic              ci, is_sub, use_c, arith, wb, setf, op_ok, ill;
  logic              am, bm, resm, cf, ofl;

  assign immx = (d && w) ? DATA_W'($signed(imm[7:0])) : DATA_W'(imm);
  assign a    = rf_q[dst_idx];
  assign b    = is_imm ? immx : rf_q[src_idx];

  // opcode decode: operation class, writeback and flag enables
  always_comb begin
    lw     = '0;
    arith  = 1'b0;
    is_sub = 1'b0;
    use_c  = 1'b0;
    wb     = 1'b1;
    setf   = 1'b1;
    op_ok  = 1'b1;
    case (op)
      OP_ADD: arith = 1'b1;
      OP_ADC: begin arith = 1'b1; use_c = 1'b1; end
      OP_SUB: begin arith = 1'b1; is_sub = 1'b1; end
      OP_SBB: begin
        arith = 1'b1; is_sub = 1'b1; use_c = 1'b1;
      end
      OP_CMP: begin
        arith = 1'b1; is_sub = 1'b1; wb = 1'b0;
      end
      OP_OR:  lw = a | b;
      OP_AND: lw = a & b;
      OP_XOR: lw = a ^ b;
      OP_MOV: begin lw = b; setf = 1'b0; end
      default: begin op_ok = 1'b0; wb = 1'b0; setf = 1'b0; end
    endcase
  end

  assign ill = !op_ok || !(reg_mode || is_imm) ||
               !({1'b0, rg} < NR) || !({1'b0, rm} < NR);

  assign ci = use_c && flags_q[0];
  assign sw = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
  assign dw = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, ci};
  assign s8 = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, ci};
  assign d8 = {1'b0, a[7:0]} - {1'b0, b[7:0]} - {8'b0, ci};
  assign rw = is_sub ? dw : sw;
  assign r8 = is_sub ? d8 : s8;

  // result and flag formation for word or byte width
  always_comb begin
    rwid = arith ? rw[DATA_W-1:0] : lw;
    rbyt = arith ? r8[7:0] : lw[7:0];
    newv = w ? rwid : {a[DATA_W-1:8], rbyt};
    am   = w ? a[DATA_W-1] : a[7];
    bm   = w ? b[DATA_W-1] : b[7];
    resm = w ? rwid[DATA_W-1] : rbyt[7];
    cf   = arith && (w ? rw[DATA_W] : r8[8]);
    ofl  = arith && (is_sub ? (am != bm) && (resm != am)
                            : (am == bm) && (resm != am));
    flags_d     = 16'h0000;
    flags_d[0]  = cf;
    flags_d[2]  = ~^newv[7:0];
    flags_d[6]  = w ? (rwid == '0) : (rbyt == 8'h00);
    flags_d[7]  = resm;
    flags_d[11] = ofl;
    res_d = ill ? '0 : (wb ? newv : a);
  end

  // register file: preload port, EX writeback takes priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (wr_en && ({1'b0, wr_sel} < NR)) rf_q[wr_sel] <= wr_data;
      if (fire && !ill && wb) rf_q[dst_idx] <= newv;
    end
  end

  // EX output register, flags and handshake state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (flush) begin
      rv_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (fire) begin
      rv_q     <= 1'b1;
      err_q    <= ill;
      result_q <= res_d;
      if (!ill && setf) flags_q <= flags_d;
    end else if (rv_q && res_ready) begin
      rv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eu_exec_pipe.sv
// Scoreboard bench for eu_exec_pipe: expected results queued on issue,
// compared when the result handshake completes.
module tb_eu_exec_pipe;

  logic        clk = 0, reset = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_word = '0;
  logic        flush = 0, res_valid, res_ready = 1;
  logic [15:0] result, status, wr_data = '0, dbg_data;
  logic        err, wr_en = 0;
  logic [2:0]  wr_sel = '0, dbg_sel = '0;

  eu_exec_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .status(status), .err(err),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] st;
    logic        er;
    logic        cr;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(
    input logic [5:0] op, input logic d, input logic w,
    input logic [1:0] md, input logic [2:0] rg, input logic [2:0] rm);
    return {op, d, w, md, rg, rm};
  endfunction

  // result consumer side of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset && res_valid && res_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexp_res", 32'(res_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        if (e.cr) chk("res", 32'(result), 32'(e.res));
        chk("status", 32'(status), 32'(e.st));
        chk("err", 32'(err), 32'(e.er));
      end
    end
  end

  task automatic send(input logic [31:0] wd, input logic eon,
                      input logic [15:0] er, input logic [15:0] es,
                      input logic ee, input logic cr);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1;
    in_word  = wd;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'(1));
    else if (eon) begin
      e.res = er; e.st = es; e.er = ee; e.cr = cr;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic pre(input logic [2:0] s, input logic [15:0] v);
    wr_en = 1; wr_sel = s; wr_data = v;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic dchk(input string tag, input logic [2:0] s,
                      input logic [15:0] v);
    dbg_sel = s;
    #1;
    chk(tag, 32'(dbg_data), 32'(v));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  localparam logic [5:0] ADD = 6'b000000, OR_ = 6'b000010;
  localparam logic [5:0] ADC = 6'b000100, SBB = 6'b000110;
  localparam logic [5:0] AND_ = 6'b001000, SUB = 6'b001010;
  localparam logic [5:0] XOR_ = 6'b001100, CMP = 6'b001110;
  localparam logic [5:0] MOV = 6'b100010;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rv", 32'(res_valid), 32'(0));
    chk("rst_ir", 32'(in_ready), 32'(1));
    chk("rst_res", 32'(result), 32'(0));
    chk("rst_st", 32'(status), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    reset = 1;
    @(posedge clk); #1;
    dchk("rst_r0", 3'd0, 16'h0000);

    // signed overflow into the sign bit, reg-reg d=0
    pre(3'd0, 16'h7FFF);
    pre(3'd1, 16'h0001);
    send({ins(ADD, 0, 1, 2'b11, 3'd1, 3'd0), 16'h0}, 1,
         16'h8000, 16'h0884, 0, 1);
    @(negedge clk); chk("lat_t1", 32'(res_valid), 32'(0));
    @(negedge clk); chk("lat_t2", 32'(res_valid), 32'(1));
    drain("drain1");
    dchk("t1_r0", 3'd0, 16'h8000);

    // carry chain through ADC with back-to-back issue
    pre(3'd2, 16'hFF01);
    send({ins(ADD, 0, 1, 2'b00, 3'd0, 3'd2), 16'h00FF}, 1,
         16'h0000, 16'h0045, 0, 1);
    send({ins(ADC, 0, 1, 2'b00, 3'd0, 3'd2), 16'h0000}, 1,
         16'h0001, 16'h0000, 0, 1);
    drain("drain2");

    // byte-mode SUB keeps upper bits; CMP leaves dst alone
    pre(3'd3, 16'h12F0);
    send({ins(SUB, 0, 0, 2'b00, 3'd0, 3'd3), 16'h00F0}, 1,
         16'h1200, 16'h0044, 0, 1);
    send({ins(CMP, 0, 1, 2'b11, 3'd3, 3'd3), 16'h0}, 1,
         16'h0, 16'h0044, 0, 0);
    send({ins(XOR_, 1, 1, 2'b11, 3'd2, 3'd1), 16'h0}, 1,
         16'h0000, 16'h0044, 0, 1);
    drain("drain3");
    dchk("t3_r3", 3'd3, 16'h1200);
    dchk("xor_r2", 3'd2, 16'h0000);
    dchk("xor_r1", 3'd1, 16'h0001);

    // illegal mod and opcode, then a legal op
    send({ins(ADD, 0, 1, 2'b01, 3'd0, 3'd0), 16'h1234}, 1,
         16'h0000, 16'h0044, 1, 1);
    send({ins(6'b111111, 0, 1, 2'b11, 3'd1, 3'd0), 16'h0}, 1,
         16'h0000, 16'h0044, 1, 1);
    send({ins(OR_, 0, 1, 2'b00, 3'd0, 3'd1), 16'h8000}, 1,
         16'h8001, 16'h0080, 0, 1);
    drain("drain5");
    dchk("ill_r0", 3'd0, 16'h8000);

    // sign-extended immediate, borrow chain, logic op
    send({ins(ADD, 1, 1, 2'b00, 3'd0, 3'd5), 16'h0080}, 1,
         16'hFF80, 16'h0080, 0, 1);
    send({ins(SUB, 0, 1, 2'b00, 3'd0, 3'd6), 16'h0001}, 1,
         16'hFFFF, 16'h0085, 0, 1);
    send({ins(SBB, 0, 1, 2'b00, 3'd0, 3'd6), 16'h0000}, 1,
         16'hFFFE, 16'h0080, 0, 1);
    send({ins(AND_, 0, 1, 2'b00, 3'd0, 3'd6), 16'h00F0}, 1,
         16'h00F0, 16'h0004, 0, 1);
    pre(3'd7, 16'hAB80);
    send({ins(ADD, 0, 0, 2'b00, 3'd0, 3'd7), 16'h0080}, 1,
         16'hAB00, 16'h0845, 0, 1);
    drain("drain_alu");

    // back-pressure: 4 queued + 1 held, then release
    res_ready = 0;
    acc = 0;
    for (int c = 0; c < 12 && acc < 6; c++) begin
      in_valid = 1;
      in_word  = {ins(MOV, 0, 1, 2'b00, 3'd0, 3'd4),
                  16'(16'h1000 + acc)};
      @(negedge clk);
      if (!in_ready) break;
      e.res = 16'(16'h1000 + acc); e.st = 16'h0845;
      e.er = 0; e.cr = 1;
      sb.push_back(e);
      acc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("bp_accepted", 32'(acc), 32'(5));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    chk("hold_rv", 32'(res_valid), 32'(1));
    chk("hold_res", 32'(result), 32'h1000);
    @(posedge clk); #1;
    res_ready = 1;
    send({ins(MOV, 0, 1, 2'b00, 3'd0, 3'd4), 16'h1005}, 1,
         16'h1005, 16'h0845, 0, 1);
    drain("drain_bp");

    // flush with one held result and three queued
    res_ready = 0;
    for (int k = 0; k < 4; k++)
      send({ins(MOV, 0, 1, 2'b00, 3'd0, 3'd4), 16'(16'hA000 + k)},
           0, 16'h0, 16'h0, 0, 0);
    flush = 1;
    in_valid = 1;
    in_word = {ins(MOV, 0, 1, 2'b00, 3'd0, 3'd4), 16'hBEEF};
    @(negedge clk);
    chk("fl_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("fl_rv", 32'(res_valid), 32'(0));
    chk("fl_ir", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    res_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    dchk("fl_r4", 3'd4, 16'hA000);
    dchk("fl_r0", 3'd0, 16'h8000);
    send({ins(MOV, 0, 1, 2'b00, 3'd0, 3'd4), 16'h5555}, 1,
         16'h5555, 16'h0845, 0, 1);
    drain("drain_fl");

    // reset lands before the fire edge of an accepted word
    send({ins(MOV, 0, 1, 2'b00, 3'd0, 3'd5), 16'h7777}, 0,
         16'h0, 16'h0, 0, 0);
    reset = 0;
    @(negedge clk);
    chk("ar_rv", 32'(res_valid), 32'(0));
    chk("ar_ir", 32'(in_ready), 32'(1));
    chk("ar_res", 32'(result), 32'(0));
    chk("ar_st", 32'(status), 32'(0));
    @(posedge clk); #1;
    reset = 1;
    dchk("ar_r5", 3'd5, 16'h0000);
    dchk("ar_r0", 3'd0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    send({ins(ADD, 0, 1, 2'b00, 3'd0, 3'd1), 16'h0001}, 1,
         16'h0001, 16'h0000, 0, 1);
    drain("drain_end");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
